// File: rtl/tapasco_reset_pkg.sv
// Shared types and default delays for the TaPaSCo reset sequencer.
package tapasco_reset_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_IC_RELEASED,
        ST_RUN,
        ST_DESIGN_RST
    } state_e;

    localparam int DEF_ASSERT_CYCLES = 16;
    localparam int DEF_PERIPH_DELAY  = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_CNT_W         = 16;

    typedef struct packed {
        logic host_ic;
        logic design_ic;
        logic mem_ic;
        logic host_per;
        logic design_per;
        logic mem_per;
    } rst_vec_t;

    // Active-high reset pattern that each state drives onto the bridge.
    function automatic rst_vec_t reset_vec(input state_e s);
        rst_vec_t v;
        v = '1;
        case (s)
            ST_IC_RELEASED: v = '{host_ic: 1'b0, design_ic: 1'b0, mem_ic: 1'b0,
                                  host_per: 1'b1, design_per: 1'b1, mem_per: 1'b1};
            ST_RUN:         v = '0;
            ST_DESIGN_RST:  v = '{host_ic: 1'b0, design_ic: 1'b0, mem_ic: 1'b0,
                                  host_per: 1'b0, design_per: 1'b1, mem_per: 1'b0};
            default:        v = '1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tapasco_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
module tapasco_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tapasco_reset_sequencer.sv
// Sequences host/design/mem interconnect and peripheral resets on clock lock,
// and serves software full resets and design-only reset pulses.
module tapasco_reset_sequencer
    import tapasco_reset_pkg::*;
#(
    parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
    parameter int PERIPH_DELAY  = DEF_PERIPH_DELAY,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic i_host_clk,
    input  logic i_reset,
    input  logic i_mem_locked,
    input  logic i_design_locked,
    input  logic i_sw_reset_req,
    input  logic i_design_reset_req,
    output logic o_host_interconnect_reset,
    output logic o_host_interconnect_resetn,
    output logic o_design_interconnect_reset,
    output logic o_design_interconnect_resetn,
    output logic o_mem_interconnect_reset,
    output logic o_mem_interconnect_resetn,
    output logic o_host_peripheral_reset,
    output logic o_host_peripheral_resetn,
    output logic o_design_peripheral_reset,
    output logic o_design_peripheral_resetn,
    output logic o_mem_peripheral_reset,
    output logic o_mem_peripheral_resetn,
    output logic o_busy,
    output logic o_lock_timeout
);

    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic mem_locked, design_locked, locked, lock_lost;
    logic locked_prev_q;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic timeout_q, timeout_d;
    rst_vec_t rst_q, rst_d;
    logic busy_q, busy_d;

    tapasco_sync2 u_sync_mem (
        .clk_i (i_host_clk),
        .rst_i (i_reset),
        .d_i   (i_mem_locked),
        .q_o   (mem_locked)
    );

    tapasco_sync2 u_sync_design (
        .clk_i (i_host_clk),
        .rst_i (i_reset),
        .d_i   (i_design_locked),
        .q_o   (design_locked)
    );

    assign locked    = mem_locked & design_locked;
    // Loss of lock is an event, so ASSERT can keep counting while unlocked.
    assign lock_lost = locked_prev_q & ~locked;

    always_ff @(posedge i_host_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            locked_prev_q <= 1'b0;
            rst_q         <= '1;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            locked_prev_q <= locked;
            rst_q         <= rst_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        timeout_d = i_sw_reset_req ? 1'b0 : timeout_q;
        if (i_sw_reset_req || lock_lost) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == ASSERT_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked) begin
                        state_d = ST_IC_RELEASED;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q == TIMEOUT_MAX) cnt_d = cnt_q;
                        if (cnt_d == TIMEOUT_MAX) timeout_d = 1'b1;
                    end
                end
                ST_IC_RELEASED: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (i_design_reset_req) state_d = ST_DESIGN_RST;
                end
                ST_DESIGN_RST: begin
                    if (i_design_reset_req) begin
                        cnt_d = '0;
                    end else if (cnt_q == PERIPH_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered copies of the next-state decode.
    always_comb begin
        rst_d  = reset_vec(state_d);
        busy_d = (state_d != ST_RUN);
    end

    assign o_host_interconnect_reset    = rst_q.host_ic;
    assign o_host_interconnect_resetn   = ~rst_q.host_ic;
    assign o_design_interconnect_reset  = rst_q.design_ic;
    assign o_design_interconnect_resetn = ~rst_q.design_ic;
    assign o_mem_interconnect_reset     = rst_q.mem_ic;
    assign o_mem_interconnect_resetn    = ~rst_q.mem_ic;
    assign o_host_peripheral_reset      = rst_q.host_per;
    assign o_host_peripheral_resetn     = ~rst_q.host_per;
    assign o_design_peripheral_reset    = rst_q.design_per;
    assign o_design_peripheral_resetn   = ~rst_q.design_per;
    assign o_mem_peripheral_reset       = rst_q.mem_per;
    assign o_mem_peripheral_resetn      = ~rst_q.mem_per;
    assign o_busy                       = busy_q;
    assign o_lock_timeout               = timeout_q;

endmodule

// File: tb/tb_tapasco_reset_sequencer.sv
// Directed bench for tapasco_reset_sequencer (ASSERT_CYCLES=4, PERIPH_DELAY=3, LOCK_TIMEOUT=10).
module tb_tapasco_reset_sequencer;

    logic clk = 1'b0;
    logic i_reset, i_mem_locked, i_design_locked, i_sw_reset_req, i_design_reset_req;
    logic hic, hicn, dic, dicn, mic, micn, hp, hpn, dp, dpn, mp, mpn;
    logic busy, lock_to;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [5:0] ALL_RST = 6'b111111;
    localparam logic [5:0] PER_RST = 6'b000111;
    localparam logic [5:0] NO_RST  = 6'b000000;
    localparam logic [5:0] DSN_RST = 6'b000010;

    always #5 clk = ~clk;

    tapasco_reset_sequencer #(
        .ASSERT_CYCLES (4),
        .PERIPH_DELAY  (3),
        .LOCK_TIMEOUT  (10),
        .CNT_W         (16)
    ) dut (
        .i_host_clk                   (clk),
        .i_reset                      (i_reset),
        .i_mem_locked                 (i_mem_locked),
        .i_design_locked              (i_design_locked),
        .i_sw_reset_req               (i_sw_reset_req),
        .i_design_reset_req           (i_design_reset_req),
        .o_host_interconnect_reset    (hic),
        .o_host_interconnect_resetn   (hicn),
        .o_design_interconnect_reset  (dic),
        .o_design_interconnect_resetn (dicn),
        .o_mem_interconnect_reset     (mic),
        .o_mem_interconnect_resetn    (micn),
        .o_host_peripheral_reset      (hp),
        .o_host_peripheral_resetn     (hpn),
        .o_design_peripheral_reset    (dp),
        .o_design_peripheral_resetn   (dpn),
        .o_mem_peripheral_reset       (mp),
        .o_mem_peripheral_resetn      (mpn),
        .o_busy                       (busy),
        .o_lock_timeout               (lock_to)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Order: {host_ic, design_ic, mem_ic, host_per, design_per, mem_per}
    task automatic expect_out(input string tag, input logic [5:0] exp_rst, input logic exp_busy);
        logic [5:0] exp_n;
        exp_n = ~exp_rst;
        chk({tag, "_rst"},  {26'd0, hic, dic, mic, hp, dp, mp}, {26'd0, exp_rst});
        chk({tag, "_rstn"}, {26'd0, hicn, dicn, micn, hpn, dpn, mpn}, {26'd0, exp_n});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge 0 is the edge that entered ASSERT (or the last reset edge); locks high.
    task automatic release_seq(input string tag, input bit poke_design);
        for (int e = 1; e <= 8; e++) begin
            if (poke_design && e == 6) i_design_reset_req = 1'b1;
            tick();
            i_design_reset_req = 1'b0;
            if (e < 5)      expect_out($sformatf("%s_e%0d", tag, e), ALL_RST, 1'b1);
            else if (e < 8) expect_out($sformatf("%s_e%0d", tag, e), PER_RST, 1'b1);
            else            expect_out($sformatf("%s_e%0d", tag, e), NO_RST, 1'b0);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_mem_locked = 1'b1;
        i_design_locked = 1'b1;
        i_sw_reset_req = 1'b0;
        i_design_reset_req = 1'b0;
        #2;
        expect_out("por", ALL_RST, 1'b1);
        chk("por_timeout", {31'd0, lock_to}, 32'd0);

        @(posedge clk);
        #1 i_reset = 1'b0;
        release_seq("boot", 1'b0);

        // Design-only pulse from RUN.
        i_design_reset_req = 1'b1;
        tick();
        i_design_reset_req = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            expect_out($sformatf("dsn_p%0d", e), DSN_RST, 1'b1);
            tick();
        end
        expect_out("dsn_end", NO_RST, 1'b0);

        // Memory lock loss in RUN, then recovery (design request ignored in IC_RELEASED).
        i_mem_locked = 1'b0;
        tick();
        expect_out("loss_1", NO_RST, 1'b0);
        tick();
        expect_out("loss_2", NO_RST, 1'b0);
        tick();
        expect_out("loss_3", ALL_RST, 1'b1);
        i_mem_locked = 1'b1;
        release_seq("relock", 1'b1);

        // Software and design requests in the same RUN cycle.
        i_sw_reset_req = 1'b1;
        i_design_reset_req = 1'b1;
        tick();
        i_sw_reset_req = 1'b0;
        i_design_reset_req = 1'b0;
        expect_out("dual", ALL_RST, 1'b1);
        release_seq("dual", 1'b0);

        // Lock timeout with the design clock unlocked from reset.
        i_reset = 1'b1;
        i_design_locked = 1'b0;
        @(posedge clk);
        #1 i_reset = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 13) chk("to_e13", {31'd0, lock_to}, 32'd0);
            if (e == 14) chk("to_e14", {31'd0, lock_to}, 32'd1);
        end
        expect_out("to_hold", ALL_RST, 1'b1);
        chk("to_e20", {31'd0, lock_to}, 32'd1);
        i_design_locked = 1'b1;
        for (int e = 21; e <= 26; e++) begin
            tick();
            if (e < 23)      expect_out($sformatf("to_e%0d", e), ALL_RST, 1'b1);
            else if (e < 26) expect_out($sformatf("to_e%0d", e), PER_RST, 1'b1);
            else             expect_out($sformatf("to_e%0d", e), NO_RST, 1'b0);
        end
        chk("to_sticky", {31'd0, lock_to}, 32'd1);
        i_sw_reset_req = 1'b1;
        tick();
        i_sw_reset_req = 1'b0;
        expect_out("sw", ALL_RST, 1'b1);
        chk("sw_clear", {31'd0, lock_to}, 32'd0);
        release_seq("post_sw", 1'b0);

        // Asynchronous reset while interconnects are released.
        i_sw_reset_req = 1'b1;
        tick();
        i_sw_reset_req = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        expect_out("icrel", PER_RST, 1'b1);
        i_reset = 1'b1;
        #2;
        expect_out("async", ALL_RST, 1'b1);
        chk("async_timeout", {31'd0, lock_to}, 32'd0);
        @(posedge clk);
        #1 i_reset = 1'b0;
        release_seq("final", 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
